// File: rtl/stream_demux_1xn.sv
// 1-to-N valid/ready demultiplexer with one registered slot per output channel.
// Optional per-channel beat counters and a drop counter are enabled with DEMUX_CNT_EN.
module stream_demux_1xn #(
  parameter int  DATA_W = 8,
  parameter int  N_OUT  = 4,
  localparam int SEL_W  = $clog2(N_OUT)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic [SEL_W-1:0]        in_sel,
  output logic [N_OUT-1:0]        out_valid,
  input  logic [N_OUT-1:0]        out_ready,
  output logic [N_OUT*DATA_W-1:0] out_data,
  output logic                    drop_pulse
`ifdef DEMUX_CNT_EN
  ,
  input  logic                    cnt_clr,
  output logic [N_OUT*16-1:0]     cnt_beats,
  output logic [15:0]             cnt_drop
`endif
);

  // Handshake rule on both sides: a beat moves on a rising edge where valid & ready.
  // in_ready never looks at in_valid, and out_valid is never withdrawn before its handshake.
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_state_t;

  slot_state_t       state_q [N_OUT];
  slot_state_t       state_d [N_OUT];
  logic [DATA_W-1:0] data_q  [N_OUT];

  logic [N_OUT-1:0] hit;
  logic [N_OUT-1:0] load;
  logic [N_OUT-1:0] drain;
  logic             sel_in_range;
  logic             accept;
  logic             drop_q;

  assign sel_in_range = ({1'b0, in_sel} < (SEL_W + 1)'(N_OUT));

  always_comb begin
    hit = '0;
    for (int k = 0; k < N_OUT; k++) begin
      hit[k] = (in_sel == SEL_W'(k));
    end
  end

  // out_valid is the slot state itself, so it doubles as the FSM debug view.
  always_comb begin
    out_valid = '0;
    out_data  = '0;
    for (int k = 0; k < N_OUT; k++) begin
      out_valid[k]                  = (state_q[k] == FULL);
      out_data[k*DATA_W +: DATA_W]  = data_q[k];
    end
  end

  // Out-of-range beats are always consumed so a bad select cannot wedge the producer.
  assign in_ready = ~sel_in_range | (|(hit & (~out_valid | out_ready)));
  assign accept   = in_valid & in_ready;
  assign load     = hit & {N_OUT{accept & sel_in_range}};
  assign drain    = out_valid & out_ready;

  always_comb begin
    for (int k = 0; k < N_OUT; k++) begin
      state_d[k] = state_q[k];
      unique case (state_q[k])
        EMPTY:   if (load[k]) state_d[k] = FULL;
        FULL:    if (drain[k] && !load[k]) state_d[k] = EMPTY;
        default: state_d[k] = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_OUT; k++) begin
        state_q[k] <= EMPTY;
        data_q[k]  <= '0;
      end
      drop_q <= 1'b0;
    end else begin
      for (int k = 0; k < N_OUT; k++) begin
        state_q[k] <= state_d[k];
        if (load[k]) data_q[k] <= in_data;
      end
      drop_q <= accept & ~sel_in_range;
    end
  end

  assign drop_pulse = drop_q;

`ifdef DEMUX_CNT_EN
  logic [15:0] beat_cnt_q [N_OUT];
  logic [15:0] drop_cnt_q;

  // Clear has priority over any increment landing on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_OUT; k++) beat_cnt_q[k] <= '0;
      drop_cnt_q <= '0;
    end else if (cnt_clr) begin
      for (int k = 0; k < N_OUT; k++) beat_cnt_q[k] <= '0;
      drop_cnt_q <= '0;
    end else begin
      for (int k = 0; k < N_OUT; k++) begin
        if (drain[k] && (beat_cnt_q[k] != 16'hFFFF)) beat_cnt_q[k] <= beat_cnt_q[k] + 16'd1;
      end
      if (accept && !sel_in_range && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  always_comb begin
    cnt_beats = '0;
    for (int k = 0; k < N_OUT; k++) cnt_beats[k*16 +: 16] = beat_cnt_q[k];
  end

  assign cnt_drop = drop_cnt_q;
`endif

endmodule

// File: tb/tb_stream_demux_1xn.sv
// Bench for stream_demux_1xn with N_OUT=5 so selects 5..7 exercise the drop path.
// A per-channel queue model predicts readiness, output data, drops and (with DEMUX_CNT_EN) counters.
module tb_stream_demux_1xn;
  localparam int N = 5;
  localparam int W = 8;
  localparam int SW = $clog2(N);
  localparam logic [N-1:0] ALL1 = '1;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [SW-1:0] in_sel;
  logic [N-1:0]  out_valid;
  logic [N-1:0]  out_ready;
  logic [N*W-1:0] out_data;
  logic          drop_pulse;
`ifdef DEMUX_CNT_EN
  logic          cnt_clr;
  logic [N*16-1:0] cnt_beats;
  logic [15:0]   cnt_drop;
  logic [15:0]   mdl_beats [N];
  logic [15:0]   mdl_drop;
`endif

  logic [W-1:0] exp_q [N][$];
  logic         drop_next;
  logic         last_acc;
  int           acc_cnt;
  int           total;
  int           bad;

  stream_demux_1xn #(.DATA_W(W), .N_OUT(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .drop_pulse(drop_pulse)
`ifdef DEMUX_CNT_EN
    , .cnt_clr(cnt_clr), .cnt_beats(cnt_beats), .cnt_drop(cnt_drop)
`endif
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: inputs change 1 after the rising edge; acceptance is recorded after the monitor ran
  task automatic drive(input logic v, input logic [SW-1:0] sel, input logic [W-1:0] d,
                       input logic [N-1:0] rdy, input logic clr);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_sel    = sel;
    in_data   = d;
    out_ready = rdy;
`ifdef DEMUX_CNT_EN
    cnt_clr   = clr;
`endif
    #6;
    last_acc = in_valid && in_ready;
    if (last_acc) begin
      acc_cnt++;
      if (int'(sel) < N) exp_q[sel].push_back(d);
      else begin
        drop_next = 1'b1;
`ifdef DEMUX_CNT_EN
        if (!clr && mdl_drop != 16'hFFFF) mdl_drop++;
`endif
      end
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < N; k++) exp_q[k].delete();
    drop_next = 1'b0;
`ifdef DEMUX_CNT_EN
    for (int k = 0; k < N; k++) mdl_beats[k] = '0;
    mdl_drop = '0;
`endif
  endtask

  task automatic reset_check();
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    clear_model();
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_drop_pulse", 64'(drop_pulse), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int s = 0; s < N; s++) begin
      in_sel = SW'(s);
      #1;
      check("rdy_after_rst", 64'(in_ready), 64'd1);
    end
  endtask

  // scoreboard monitor: compares the DUT to the queue model, then retires handshakes
  always @(negedge clk) begin
    if (rst_n) begin
      logic exp_rdy;
      if (int'(in_sel) >= N) exp_rdy = 1'b1;
      else exp_rdy = (exp_q[in_sel].size() == 0) || out_ready[in_sel];
      check("in_ready", 64'(in_ready), 64'(exp_rdy));
      check("drop_pulse", 64'(drop_pulse), 64'(drop_next));
      drop_next = 1'b0;
`ifdef DEMUX_CNT_EN
      check("cnt_drop", 64'(cnt_drop), 64'(mdl_drop));
      for (int k = 0; k < N; k++) check("cnt_beats", 64'(cnt_beats[k*16 +: 16]), 64'(mdl_beats[k]));
      if (cnt_clr) begin
        for (int k = 0; k < N; k++) mdl_beats[k] = '0;
        mdl_drop = '0;
      end
`endif
      for (int k = 0; k < N; k++) begin
        logic exp_v;
        exp_v = (exp_q[k].size() != 0);
        check("out_valid", 64'(out_valid[k]), 64'(exp_v));
        if (exp_v) begin
          check("out_data", 64'(out_data[k*W +: W]), 64'(exp_q[k][0]));
          if (out_ready[k]) begin
            void'(exp_q[k].pop_front());
`ifdef DEMUX_CNT_EN
            if (!cnt_clr && mdl_beats[k] != 16'hFFFF) mdl_beats[k]++;
`endif
          end
        end
      end
    end
  end

  initial begin
    total = 0; bad = 0; acc_cnt = 0; last_acc = 1'b0;
    rst_n = 1'b0; in_valid = 1'b0; in_sel = '0; in_data = '0; out_ready = '0;
`ifdef DEMUX_CNT_EN
    cnt_clr = 1'b0;
`endif
    clear_model();
    reset_check();

    // routing: four back-to-back beats, all consumers ready
    acc_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, SW'(k), W'(8'hA0 + k), ALL1, 1'b0);
      check("route_ready", 64'(in_ready), 64'd1);
    end
    check("route_accepts", 64'(acc_cnt), 64'd4);
    drive(1'b0, '0, '0, ALL1, 1'b0);
    check("route_last_valid", 64'(out_valid), 64'(5'b01000));
    check("route_last_data", 64'(out_data[3*W +: W]), 64'hA3);
    drive(1'b0, '0, '0, ALL1, 1'b0);

    // backpressure isolation on channel 2
    drive(1'b1, 3'd2, 8'hB1, 5'b11011, 1'b0);
    check("bp_first_acc", 64'(last_acc), 64'd1);
    drive(1'b1, 3'd2, 8'hB2, 5'b11011, 1'b0);
    check("bp_blocked", 64'(in_ready), 64'd0);
    drive(1'b1, 3'd1, 8'hC1, 5'b11011, 1'b0);
    check("bp_other_pass", 64'(in_ready), 64'd1);
    check("bp_held_data", 64'(out_data[2*W +: W]), 64'hB1);
    drive(1'b1, 3'd2, 8'hB2, ALL1, 1'b0);
    check("bp_reload_ready", 64'(in_ready), 64'd1);
    drive(1'b0, '0, '0, ALL1, 1'b0);
    check("bp_no_bubble", 64'(out_valid[2]), 64'd1);
    check("bp_reload_data", 64'(out_data[2*W +: W]), 64'hB2);
    drive(1'b0, '0, '0, ALL1, 1'b0);

    // out-of-range select
    drive(1'b1, 3'd5, 8'h55, ALL1, 1'b0);
    check("oor_ready", 64'(in_ready), 64'd1);
    drive(1'b0, '0, '0, ALL1, 1'b0);
    check("oor_pulse", 64'(drop_pulse), 64'd1);
    check("oor_no_valid", 64'(out_valid), 64'd0);
    drive(1'b0, '0, '0, ALL1, 1'b0);
    check("oor_pulse_end", 64'(drop_pulse), 64'd0);

    // simultaneous drain and load on channel 0
    drive(1'b1, 3'd0, 8'h11, 5'b11110, 1'b0);
    drive(1'b1, 3'd0, 8'h22, ALL1, 1'b0);
    check("dl_ready", 64'(in_ready), 64'd1);
    check("dl_old_data", 64'(out_data[0 +: W]), 64'h11);
    drive(1'b0, '0, '0, ALL1, 1'b0);
    check("dl_valid", 64'(out_valid[0]), 64'd1);
    check("dl_new_data", 64'(out_data[0 +: W]), 64'h22);

    // randomized traffic with a reset in the middle
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) reset_check();
      drive($urandom_range(0, 3) != 0, SW'($urandom_range(0, 7)), W'($urandom),
            N'($urandom_range(0, 31)), $urandom_range(0, 99) == 0);
    end

`ifdef DEMUX_CNT_EN
    reset_check();
    for (int i = 0; i < 70000; i++) drive(1'b1, 3'd0, W'($urandom), ALL1, 1'b0);
    drive(1'b0, '0, '0, ALL1, 1'b0);
    check("cnt_saturated", 64'(cnt_beats[0 +: 16]), 64'hFFFF);
    drive(1'b1, 3'd0, 8'h77, ALL1, 1'b0);
    drive(1'b0, '0, '0, ALL1, 1'b1);
    drive(1'b0, '0, '0, ALL1, 1'b0);
    check("cnt_clear_wins", 64'(cnt_beats[0 +: 16]), 64'd0);
`endif
    drive(1'b0, '0, '0, ALL1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
